// File: rtl/kgp_control_sequencer.sv
// kgp_control_sequencer: multi-cycle control sequencer for the KGP-RISC core.
// Turns the decoded control bundle into timed datapath strobes and retires
// one instruction per pass through FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//
// Memory handshake: a request (imem_req / dmem_re / dmem_we) is a registered
// level that is held steady for every cycle of its request state. The memory
// answers with a single-cycle ack sampled on the rising edge. An ack seen
// outside the matching request state is ignored. If the ack is not seen
// within MEM_TIMEOUT request cycles, the sequencer traps. An ack in the same
// cycle as the limit wins.
//
// Strobe timing: every output is registered. A strobe chosen on a clock edge
// is visible for the cycle that follows that edge. So reg_we/pc_we show up
// during WB, and the pc_we of a branch or store shows up in the cycle after
// EXEC or MEM. retired steps on the same edge that raises pc_we.
module kgp_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [5:0]       opcode,
  input  logic             branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             alu_source,
  input  logic [1:0]       mem_reg_pc,
  input  logic [1:0]       write_reg,
  input  logic [2:0]       alu_op,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       alu_op_q,
  output logic             alu_src_q,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;
  localparam logic [8:0] TMO_LIM       = 9'(MEM_TIMEOUT);

  state_t           state, state_n, boundary;
  logic [7:0]       tmo_cnt, tmo_n;
  logic             tmo_hit;
  logic             branch_q, mem_read_q, mem_write_q;
  logic [1:0]       write_reg_q;
  logic             branch_n, mem_read_n, mem_write_n;
  logic [1:0]       write_reg_n;
  logic             is_link, retire;
  logic             imem_req_n, ir_we_n, dmem_re_n, dmem_we_n, reg_we_n;
  logic [1:0]       wb_sel_n;
  logic             pc_we_n, pc_sel_n;
  logic [2:0]       alu_op_n;
  logic             alu_src_n, busy_n, trap_n;
  logic [1:0]       trap_cause_n;
  logic [CNT_W-1:0] retired_n;

  function automatic logic legal_opcode(input logic [5:0] op);
    case (op)
      6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
      6'b000110, 6'b111100, 6'b111101, 6'b111110, 6'b111111: legal_opcode = 1'b1;
      default:                                               legal_opcode = 1'b0;
    endcase
  endfunction

  // The counter reaches the limit on this cycle if it increments once more.
  assign tmo_hit   = ({1'b0, tmo_cnt} + 9'd1) == TMO_LIM;
  assign is_link   = branch_q && (write_reg_q == 2'b01);
  assign boundary  = halt_req ? S_IDLE : S_FETCH;
  assign state_dbg = state;

  // Next-state and next-output selection. Request levels and busy follow the
  // state being entered.
  always_comb begin
    state_n      = state;
    tmo_n        = '0;
    ir_we_n      = 1'b0;
    reg_we_n     = 1'b0;
    pc_we_n      = 1'b0;
    pc_sel_n     = pc_sel;
    wb_sel_n     = wb_sel;
    alu_op_n     = alu_op_q;
    alu_src_n    = alu_src_q;
    branch_n     = branch_q;
    mem_read_n   = mem_read_q;
    mem_write_n  = mem_write_q;
    write_reg_n  = write_reg_q;
    trap_n       = trap;
    trap_cause_n = trap_cause;
    retire       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_n = S_DECODE;
          ir_we_n = 1'b1;
        end else if (tmo_hit) begin
          state_n      = S_TRAP;
          trap_n       = 1'b1;
          trap_cause_n = CAUSE_IMEM;
        end else begin
          tmo_n = tmo_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (legal_opcode(opcode)) begin
          state_n     = S_EXEC;
          branch_n    = branch;
          mem_read_n  = mem_read;
          mem_write_n = mem_write;
          write_reg_n = write_reg;
          wb_sel_n    = mem_reg_pc;
          alu_op_n    = alu_op;
          alu_src_n   = alu_source;
        end else begin
          state_n      = S_TRAP;
          trap_n       = 1'b1;
          trap_cause_n = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (branch_q && !is_link) begin
          pc_we_n  = 1'b1;
          pc_sel_n = branch_taken;
          retire   = 1'b1;
          state_n  = boundary;
        end else if (is_link) begin
          // Link writes the return address in WB; the taken decision is kept.
          state_n  = S_WB;
          reg_we_n = 1'b1;
          pc_we_n  = 1'b1;
          pc_sel_n = branch_taken;
          retire   = 1'b1;
        end else if (mem_read_q || mem_write_q) begin
          state_n = S_MEM;
        end else begin
          state_n  = S_WB;
          reg_we_n = 1'b1;
          pc_we_n  = 1'b1;
          pc_sel_n = 1'b0;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          pc_we_n  = 1'b1;
          pc_sel_n = 1'b0;
          retire   = 1'b1;
          if (mem_read_q) begin
            state_n  = S_WB;
            reg_we_n = 1'b1;
          end else begin
            state_n = boundary;
          end
        end else if (tmo_hit) begin
          state_n      = S_TRAP;
          trap_n       = 1'b1;
          trap_cause_n = CAUSE_DMEM;
        end else begin
          tmo_n = tmo_cnt + 8'd1;
        end
      end
      S_WB: begin
        state_n = boundary;
      end
      S_TRAP: begin
        state_n = S_TRAP;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    imem_req_n = (state_n == S_FETCH);
    dmem_re_n  = (state_n == S_MEM) && mem_read_q;
    dmem_we_n  = (state_n == S_MEM) && !mem_read_q;
    busy_n     = (state_n != S_IDLE) && (state_n != S_TRAP);
    retired_n  = retire ? retired + CNT_W'(1) : retired;
  end

  // State, latched bundle and registered outputs; reset aborts any instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      branch_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      write_reg_q <= '0;
      imem_req    <= 1'b0;
      ir_we       <= 1'b0;
      dmem_re     <= 1'b0;
      dmem_we     <= 1'b0;
      reg_we      <= 1'b0;
      wb_sel      <= '0;
      pc_we       <= 1'b0;
      pc_sel      <= 1'b0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      busy        <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= '0;
      retired     <= '0;
    end else begin
      state       <= state_n;
      tmo_cnt     <= tmo_n;
      branch_q    <= branch_n;
      mem_read_q  <= mem_read_n;
      mem_write_q <= mem_write_n;
      write_reg_q <= write_reg_n;
      imem_req    <= imem_req_n;
      ir_we       <= ir_we_n;
      dmem_re     <= dmem_re_n;
      dmem_we     <= dmem_we_n;
      reg_we      <= reg_we_n;
      wb_sel      <= wb_sel_n;
      pc_we       <= pc_we_n;
      pc_sel      <= pc_sel_n;
      alu_op_q    <= alu_op_n;
      alu_src_q   <= alu_src_n;
      busy        <= busy_n;
      trap        <= trap_n;
      trap_cause  <= trap_cause_n;
      retired     <= retired_n;
    end
  end

endmodule
